// File: rtl/data_memory_responder.sv
// Memory-side responder for the cpu data interface.
// Services one byte read or write per request and stalls the core through
// busywait for a fixed number of cycles before completing the access.
module data_memory_responder #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int LATENCY    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  read,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] writedata,
  output logic [DATA_WIDTH-1:0] readdata,
  output logic                  busywait
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [3:0] COUNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t                  state;
  state_t                  next_state;
  logic [3:0]              counter;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    write_q;
  logic                    request;
  logic                    access_fire;
  logic                    busy_raw;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  assign request     = read | write;
  assign access_fire = (state == BUSY) && (counter == 4'd0);

  // State register; reset drops any access that is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and stall logic; DONE deliberately ignores requests so the cpu sees one free cycle.
  always_comb begin
    next_state = state;
    busy_raw   = 1'b0;
    case (state)
      IDLE: begin
        busy_raw = request;
        if (request) begin
          next_state = BUSY;
        end
      end
      BUSY: begin
        busy_raw = 1'b1;
        if (counter == 4'd0) begin
          next_state = DONE;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
    busywait = busy_raw & rst_n;
  end

  // Request capture, latency countdown and registered read result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      counter  <= 4'd0;
      addr_q   <= '0;
      wdata_q  <= '0;
      write_q  <= 1'b0;
      readdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (request) begin
            addr_q  <= address;
            wdata_q <= writedata;
            write_q <= write;
            counter <= COUNT_INIT;
          end
        end
        BUSY: begin
          if (counter != 4'd0) begin
            counter <= counter - 4'd1;
          end else if (!write_q) begin
            readdata <= mem[addr_q];
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Storage array; contents survive reset and are only written when a write access completes.
  always_ff @(posedge clk) begin
    if (access_fire && write_q) begin
      mem[addr_q] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Self-checking bench for data_memory_responder with a read-result scoreboard.
module tb_data_memory_responder;

  localparam int LAT = 4;

  logic       clk;
  logic       rst_n;
  logic       read;
  logic       write;
  logic [7:0] address;
  logic [7:0] writedata;
  logic [7:0] readdata;
  logic       busywait;

  int checks;
  int failures;

  logic [7:0] model_mem [256];
  logic [7:0] model_rd;
  logic [7:0] exp_q [$];

  data_memory_responder #(
    .ADDR_WIDTH(8),
    .DATA_WIDTH(8),
    .LATENCY   (LAT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .read     (read),
    .write    (write),
    .address  (address),
    .writedata(writedata),
    .readdata (readdata),
    .busywait (busywait)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so a stuck run still ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drives one request, counts busy cycles (bounded) and returns readdata seen in the DONE cycle.
  task automatic run_access(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] d,
                            input int change_at, input logic [7:0] new_a, input logic [7:0] new_d,
                            input bit drop, output int busy, output logic [7:0] rdata);
    @(negedge clk);
    read = rd;
    write = wr;
    address = a;
    writedata = d;
    #1;
    busy = 0;
    while (busywait === 1'b1 && busy < 40) begin
      busy++;
      if (busy == change_at) begin
        address = new_a;
        writedata = new_d;
        if (drop) begin
          read = 1'b0;
          write = 1'b0;
        end
      end
      @(negedge clk);
      #1;
    end
    rdata = readdata;
    read = 1'b0;
    write = 1'b0;
  endtask

  task automatic test_reset();
    int busy;
    rst_n = 1'b0;
    read = 1'b1;
    write = 1'b0;
    address = 8'hE0;
    writedata = 8'h00;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (busywait !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_busywait: got %b expected 0", busywait);
    end
    checks++;
    if (readdata !== 8'h00) begin
      failures++;
      $display("[TB] FAIL reset_readdata: got %h expected 00", readdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (busywait !== 1'b1) begin
      failures++;
      $display("[TB] FAIL release_busywait: got %b expected 1", busywait);
    end
    busy = 0;
    while (busywait === 1'b1 && busy < 40) begin
      busy++;
      @(negedge clk);
      #1;
    end
    read = 1'b0;
    checks++;
    if (busy != LAT + 1) begin
      failures++;
      $display("[TB] FAIL release_capture_busy: got %0d expected %0d", busy, LAT + 1);
    end
  endtask

  task automatic test_write_read();
    int busy;
    logic [7:0] rdata;
    logic [7:0] exp;
    run_access(1'b0, 1'b1, 8'h10, 8'hA5, 0, 8'h00, 8'h00, 1'b0, busy, rdata);
    model_mem[8'h10] = 8'hA5;
    checks++;
    if (busy != LAT + 1) begin
      failures++;
      $display("[TB] FAIL write_busy_cycles: got %0d expected %0d", busy, LAT + 1);
    end
    exp_q.push_back(model_mem[8'h10]);
    run_access(1'b1, 1'b0, 8'h10, 8'h00, 0, 8'h00, 8'h00, 1'b0, busy, rdata);
    model_rd = model_mem[8'h10];
    exp = exp_q.pop_front();
    checks++;
    if (rdata !== exp) begin
      failures++;
      $display("[TB] FAIL read_0x10: got %h expected %h", rdata, exp);
    end
    checks++;
    if (busy != LAT + 1) begin
      failures++;
      $display("[TB] FAIL read_busy_cycles: got %0d expected %0d", busy, LAT + 1);
    end
  endtask

  task automatic test_address_extremes();
    int busy;
    logic [7:0] rdata;
    logic [7:0] exp;
    logic [7:0] addrs [2];
    logic [7:0] datas [2];
    addrs[0] = 8'hFF;
    datas[0] = 8'hFF;
    addrs[1] = 8'h00;
    datas[1] = 8'h01;
    for (int i = 0; i < 2; i++) begin
      run_access(1'b0, 1'b1, addrs[i], datas[i], 0, 8'h00, 8'h00, 1'b0, busy, rdata);
      model_mem[addrs[i]] = datas[i];
    end
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(model_mem[addrs[i]]);
      run_access(1'b1, 1'b0, addrs[i], 8'h00, 0, 8'h00, 8'h00, 1'b0, busy, rdata);
      model_rd = model_mem[addrs[i]];
      exp = exp_q.pop_front();
      checks++;
      if (rdata !== exp) begin
        failures++;
        $display("[TB] FAIL extreme_read_%h: got %h expected %h", addrs[i], rdata, exp);
      end
    end
  endtask

  task automatic test_both_high();
    int busy;
    logic [7:0] rdata;
    logic [7:0] exp;
    run_access(1'b0, 1'b1, 8'h50, 8'h55, 0, 8'h00, 8'h00, 1'b0, busy, rdata);
    model_mem[8'h50] = 8'h55;
    exp_q.push_back(model_mem[8'h50]);
    run_access(1'b1, 1'b0, 8'h50, 8'h00, 0, 8'h00, 8'h00, 1'b0, busy, rdata);
    model_rd = model_mem[8'h50];
    exp = exp_q.pop_front();
    checks++;
    if (rdata !== exp) begin
      failures++;
      $display("[TB] FAIL setup_read_0x50: got %h expected %h", rdata, exp);
    end
    exp_q.push_back(model_rd);
    run_access(1'b1, 1'b1, 8'h20, 8'h3C, 0, 8'h00, 8'h00, 1'b0, busy, rdata);
    model_mem[8'h20] = 8'h3C;
    exp = exp_q.pop_front();
    checks++;
    if (rdata !== exp) begin
      failures++;
      $display("[TB] FAIL both_high_readdata_kept: got %h expected %h", rdata, exp);
    end
    exp_q.push_back(model_mem[8'h20]);
    run_access(1'b1, 1'b0, 8'h20, 8'h00, 0, 8'h00, 8'h00, 1'b0, busy, rdata);
    model_rd = model_mem[8'h20];
    exp = exp_q.pop_front();
    checks++;
    if (rdata !== exp) begin
      failures++;
      $display("[TB] FAIL both_high_write_0x20: got %h expected %h", rdata, exp);
    end
  endtask

  task automatic test_busy_changes();
    int busy;
    logic [7:0] rdata;
    logic [7:0] exp;
    logic [7:0] addrs [2];
    run_access(1'b0, 1'b1, 8'h31, 8'h5A, 0, 8'h00, 8'h00, 1'b0, busy, rdata);
    model_mem[8'h31] = 8'h5A;
    run_access(1'b0, 1'b1, 8'h30, 8'h77, 2, 8'h31, 8'h00, 1'b0, busy, rdata);
    model_mem[8'h30] = 8'h77;
    addrs[0] = 8'h30;
    addrs[1] = 8'h31;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(model_mem[addrs[i]]);
      run_access(1'b1, 1'b0, addrs[i], 8'h00, 0, 8'h00, 8'h00, 1'b0, busy, rdata);
      model_rd = model_mem[addrs[i]];
      exp = exp_q.pop_front();
      checks++;
      if (rdata !== exp) begin
        failures++;
        $display("[TB] FAIL busy_change_read_%h: got %h expected %h", addrs[i], rdata, exp);
      end
    end
  endtask

  task automatic test_drop_request();
    int busy;
    logic [7:0] rdata;
    logic [7:0] exp;
    run_access(1'b0, 1'b1, 8'h60, 8'h66, 2, 8'h60, 8'h66, 1'b1, busy, rdata);
    model_mem[8'h60] = 8'h66;
    checks++;
    if (busy != LAT + 1) begin
      failures++;
      $display("[TB] FAIL drop_busy_cycles: got %0d expected %0d", busy, LAT + 1);
    end
    exp_q.push_back(model_mem[8'h60]);
    run_access(1'b1, 1'b0, 8'h60, 8'h00, 0, 8'h00, 8'h00, 1'b0, busy, rdata);
    model_rd = model_mem[8'h60];
    exp = exp_q.pop_front();
    checks++;
    if (rdata !== exp) begin
      failures++;
      $display("[TB] FAIL drop_read_0x60: got %h expected %h", rdata, exp);
    end
  endtask

  task automatic test_back_to_back();
    int busy;
    logic [7:0] rdata;
    logic [7:0] exp;
    run_access(1'b0, 1'b1, 8'h70, 8'hC3, 0, 8'h00, 8'h00, 1'b0, busy, rdata);
    model_mem[8'h70] = 8'hC3;
    read = 1'b1;
    address = 8'h70;
    #1;
    checks++;
    if (busywait !== 1'b0) begin
      failures++;
      $display("[TB] FAIL done_ignores_request: got %b expected 0", busywait);
    end
    exp_q.push_back(model_mem[8'h70]);
    run_access(1'b1, 1'b0, 8'h70, 8'h00, 0, 8'h00, 8'h00, 1'b0, busy, rdata);
    model_rd = model_mem[8'h70];
    exp = exp_q.pop_front();
    checks++;
    if (busy != LAT + 1) begin
      failures++;
      $display("[TB] FAIL b2b_busy_cycles: got %0d expected %0d", busy, LAT + 1);
    end
    checks++;
    if (rdata !== exp) begin
      failures++;
      $display("[TB] FAIL b2b_read_0x70: got %h expected %h", rdata, exp);
    end
  endtask

  task automatic test_reset_mid_busy();
    int busy;
    logic [7:0] rdata;
    logic [7:0] exp;
    run_access(1'b0, 1'b1, 8'h40, 8'h11, 0, 8'h00, 8'h00, 1'b0, busy, rdata);
    model_mem[8'h40] = 8'h11;
    @(negedge clk);
    write = 1'b1;
    address = 8'h40;
    writedata = 8'h99;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_rd = 8'h00;
    checks++;
    if (busywait !== 1'b0) begin
      failures++;
      $display("[TB] FAIL abort_busywait: got %b expected 0", busywait);
    end
    checks++;
    if (readdata !== model_rd) begin
      failures++;
      $display("[TB] FAIL abort_readdata: got %h expected %h", readdata, model_rd);
    end
    write = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (busywait !== 1'b0) begin
      failures++;
      $display("[TB] FAIL abort_idle_after_release: got %b expected 0", busywait);
    end
    exp_q.push_back(model_mem[8'h40]);
    run_access(1'b1, 1'b0, 8'h40, 8'h00, 0, 8'h00, 8'h00, 1'b0, busy, rdata);
    model_rd = model_mem[8'h40];
    exp = exp_q.pop_front();
    checks++;
    if (rdata !== exp) begin
      failures++;
      $display("[TB] FAIL abort_read_0x40: got %h expected %h", rdata, exp);
    end
  endtask

  // Runs every scenario in order, then prints the summary.
  initial begin
    checks = 0;
    failures = 0;
    model_rd = 8'h00;
    test_reset();
    test_write_read();
    test_address_extremes();
    test_both_high();
    test_busy_changes();
    test_drop_request();
    test_back_to_back();
    test_reset_mid_busy();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
